// File: rtl/sdr_ctrl_pkg.sv
// Shared encodings for the SDR control blocks: NCO mode selection and
// sweep-controller FSM states.
package sdr_ctrl_pkg;

    localparam int FREQ_W = 32;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_SWEEP = 2'd1,
        MODE_HOP   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // The unused encoding 3 behaves as FIXED.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_SWEEP;
            2'd2:    return MODE_HOP;
            default: return MODE_FIXED;
        endcase
    endfunction

endpackage

// File: rtl/nco_hop_table.sv
// Hop-frequency RAM: synchronous write, registered read with write-through
// so a word written just before a pass is seen by the first read.
module nco_hop_table #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end

endmodule

// File: rtl/nco_sweep_controller.sv
// NCO frequency sequencer: holds a fixed word, sweeps by accumulation, or hops
// through a RAM table, with per-frequency dwell, looping and abort.
module nco_sweep_controller
    import sdr_ctrl_pkg::*;
#(
    parameter int TABLE_DEPTH = 8,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     cfg_mode,
    input  logic [31:0]                    cfg_start_freq,
    input  logic [31:0]                    cfg_step,
    input  logic [CNT_W-1:0]               cfg_num_steps,
    input  logic [CNT_W-1:0]               cfg_dwell,
    input  logic                           cfg_loop,
    input  logic                           tbl_wr_en,
    input  logic [$clog2(TABLE_DEPTH)-1:0] tbl_wr_addr,
    input  logic [31:0]                    tbl_wr_data,
    input  logic                           start,
    input  logic                           abort,
    output logic [31:0]                    frequency_word,
    output logic                           nco_enable,
    output logic                           busy,
    output logic                           done,
    output logic                           step_strobe,
    output logic [CNT_W-1:0]               step_index
);

    localparam int AW = $clog2(TABLE_DEPTH);

    state_e           state, state_n;
    mode_e            mode_q, mode_in;
    logic [31:0]      start_q, step_q;
    logic [CNT_W-1:0] num_q, dwell_q, dwell_cnt;
    logic [CNT_W-1:0] num_in_eff, dwell_in_eff;
    logic             loop_q;
    logic             accept, hold_end, advance, last;
    logic [CNT_W-1:0] k1;
    logic             k1_last;
    logic [AW-1:0]    rd_addr;
    logic [31:0]      rd_data;

    assign mode_in      = decode_mode(cfg_mode);
    assign num_in_eff   = (cfg_num_steps == '0) ? CNT_W'(1) : cfg_num_steps;
    assign dwell_in_eff = (cfg_dwell == '0) ? CNT_W'(1) : cfg_dwell;
    assign accept       = (state == ST_IDLE) && start && !abort;
    assign hold_end     = (dwell_cnt == dwell_q);
    assign advance      = (state == ST_RUN) && (mode_q != MODE_FIXED) && hold_end;
    assign last         = (step_index == num_q - CNT_W'(1));
    assign k1           = last ? '0 : step_index + CNT_W'(1);
    assign k1_last      = (k1 == num_q - CNT_W'(1));

    // The RAM read is registered, so the address runs one frequency ahead of
    // the next apply edge (two ahead when that edge is itself an apply edge).
    // IDLE, FIN, abort and reset park it on entry 0 for the next start.
    always_comb begin
        rd_addr = '0;
        if (rst || abort) begin
            rd_addr = '0;
        end else if (accept) begin
            rd_addr = (num_in_eff == CNT_W'(1)) ? '0 : AW'(1);
        end else if (state == ST_RUN) begin
            if (hold_end) begin
                rd_addr = k1_last ? '0 : k1[AW-1:0] + AW'(1);
            end else begin
                rd_addr = k1[AW-1:0];
            end
        end
    end

    nco_hop_table #(
        .DEPTH (TABLE_DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .wr_en   (tbl_wr_en && !busy),
        .wr_addr (tbl_wr_addr),
        .wr_data (tbl_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (advance && last && !loop_q) begin
                    state_n = ST_FIN;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            mode_q         <= MODE_FIXED;
            start_q        <= '0;
            step_q         <= '0;
            num_q          <= '0;
            dwell_q        <= '0;
            loop_q         <= 1'b0;
            dwell_cnt      <= '0;
            frequency_word <= '0;
            nco_enable     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            step_strobe    <= 1'b0;
            step_index     <= '0;
        end else begin
            state       <= state_n;
            done        <= 1'b0;
            step_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q         <= mode_in;
                        start_q        <= cfg_start_freq;
                        step_q         <= cfg_step;
                        num_q          <= num_in_eff;
                        dwell_q        <= dwell_in_eff;
                        loop_q         <= cfg_loop;
                        frequency_word <= (mode_in == MODE_HOP) ? rd_data : cfg_start_freq;
                        nco_enable     <= 1'b1;
                        busy           <= 1'b1;
                        step_strobe    <= 1'b1;
                        step_index     <= '0;
                        dwell_cnt      <= CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        nco_enable <= 1'b0;
                        busy       <= 1'b0;
                    end else if (advance) begin
                        if (last && !loop_q) begin
                            nco_enable <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            step_strobe <= 1'b1;
                            dwell_cnt   <= CNT_W'(1);
                            step_index  <= k1;
                            if (mode_q == MODE_HOP) begin
                                frequency_word <= rd_data;
                            end else if (last) begin
                                frequency_word <= start_q;
                            end else begin
                                frequency_word <= frequency_word + step_q;
                            end
                        end
                    end else if (mode_q != MODE_FIXED) begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/nco_sweep_controller.md
NCO_SWEEP_CONTROLLER -- requirements
Module: nco_sweep_controller

Interface
REQ-001 SHALL have parameter TABLE_DEPTH, default 8: number of entries in the hop table (power of two).
REQ-002 SHALL have parameter CNT_W, default 16: width of the step-count and dwell fields.
REQ-003 SHALL have port clk, input, 1: processing clock; single clock domain.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_mode, input, 2: 0 = FIXED, 1 = SWEEP, 2 = HOP; 3 is treated as FIXED.
REQ-006 SHALL have port cfg_start_freq, input, 32: first frequency word (SWEEP) and the only frequency word (FIXED).
REQ-007 SHALL have port cfg_step, input, 32: SWEEP increment, two's-complement.
REQ-008 SHALL have port cfg_num_steps, input, CNT_W: number of frequencies per pass; 0 is treated as 1.
REQ-009 SHALL have port cfg_dwell, input, CNT_W: cycles each frequency is held; 0 is treated as 1.
REQ-010 SHALL have port cfg_loop, input, 1: when 1, restart the pass instead of finishing.
REQ-011 SHALL have ports tbl_wr_en (input, 1), tbl_wr_addr (input, log2(TABLE_DEPTH)) and tbl_wr_data (input, 32): hop-table write port.
REQ-012 SHALL have ports start and abort, both input, 1: single-cycle command pulses.
REQ-013 SHALL have ports frequency_word (output, 32) and nco_enable (output, 1): these drive the NCO.
REQ-014 SHALL have ports busy (output, 1), done (output, 1, pulse), step_strobe (output, 1, pulse) and step_index (output, CNT_W).

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and FIN.
- IDLE -> RUN on start.
- RUN -> FIN at the end of a pass when cfg_loop = 0.
- FIN -> IDLE unconditionally after 1 cycle.
REQ-016 SHALL latch all cfg_* inputs on the cycle start is accepted; later changes to cfg_* SHALL have no effect until the next start.
REQ-017 SHALL, on the cycle after an accepted start:
- drive frequency_word = cfg_start_freq (FIXED/SWEEP) or table[0] (HOP);
- assert nco_enable = 1, busy = 1, step_strobe = 1;
- drive step_index = 0.
REQ-018 SHALL hold each frequency for exactly max(cfg_dwell, 1) cycles, then apply the next frequency with a 1-cycle step_strobe.
REQ-019 SHALL, in SWEEP, compute frequency k as cfg_start_freq + k*cfg_step modulo 2^32; it SHALL be computed by accumulation, and wrap-around is legal.
REQ-020 SHALL, in HOP, use table[k mod TABLE_DEPTH] for frequency k.
REQ-021 SHALL, in FIXED, hold cfg_start_freq with nco_enable = 1 until abort; it SHALL never enter FIN and never strobe after the first strobe.
REQ-022 SHALL increment step_index per frequency and reset it to 0 at each pass restart.
REQ-023 SHALL, at the end of a pass with cfg_loop = 1, restart at k = 0 seamlessly: no idle cycle, and step_strobe asserts.
REQ-024 SHALL, in FIN:
- drive done = 1 for exactly 1 cycle;
- drive nco_enable = 0 and busy = 0;
- keep frequency_word holding its last value.
REQ-025 SHALL, on abort in RUN or FIN, enter IDLE on the next cycle with nco_enable = 0, busy = 0 and no done pulse.
REQ-026 SHALL ignore start while busy; abort asserted together with start in IDLE SHALL win, and the FSM stays in IDLE.
REQ-027 SHALL accept table writes only while busy = 0; writes while busy SHALL be dropped.
REQ-028 SHALL keep all outputs registered; there is no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, on rst, drive:
- FSM = IDLE;
- frequency_word = 0, nco_enable = 0, busy = 0, done = 0, step_strobe = 0, step_index = 0;
- all counters = 0.
REQ-030 SHALL leave hop-table contents unchanged on reset (contents are undefined after power-up).
REQ-031 SHALL give rst priority over start and abort, including mid-pass.

Structure
REQ-032 SHALL place the mode encodings and FSM state encodings in the shared package sdr_ctrl_pkg.
REQ-033 SHALL implement the hop table as one sub-module, nco_hop_table: a synchronous-write, registered-read RAM of TABLE_DEPTH x 32.

Verification
REQ-034 SWEEP stimulus: start = 0x1000_0000, step = 0x0100_0000, num = 4, dwell = 3, loop = 0.
- frequency_word SHALL be 0x1000_0000, 0x1100_0000, 0x1200_0000, 0x1300_0000, each for 3 cycles.
- done SHALL pulse on cycle 13 after start.
REQ-035 SWEEP wrap stimulus: start = 0xFF00_0000, step = 0x0100_0000, num = 2 -> frequency words SHALL be 0xFF00_0000 then 0x0000_0000.
REQ-036 HOP stimulus: table = {A0, A1, A2}, num = 5, loop = 1, dwell = 1 -> sequence SHALL be A0, A1, A2, T3, T4, A0, ... with no gap, and done never asserts.
REQ-037 Abort stimulus: abort on cycle 5 of a sweep -> nco_enable = 0 and busy = 0 on cycle 6, with no done pulse; a start issued during the sweep SHALL be ignored.
REQ-038 Zero-field stimulus: dwell = 0, num = 0 -> exactly 1 frequency held for 1 cycle, then done.
REQ-039 Reset stimulus: rst mid-FIXED run -> all outputs SHALL be 0 on the next cycle, and the table SHALL retain its previously written values.
